reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
Parametrised successor to the 8x8 single-write register file in the datapath. It provides DEPTH registers of WIDTH bits, one write port and two registered read ports. Port 2 can be replaced by an immediate operand. It adds a separate write address, a pipeline stall, optional hardwired-zero register 0, and optional write-to-read forwarding. It sits between instruction decode and the ALU operand latches.

Parameters:
WIDTH, 8, data width of each register and of all data ports
DEPTH, 8, number of registers; must be a power of two, at least 2
ADDR_W, $clog2(DEPTH), register address width (derived; not overridden)
ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are discarded

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  1 = hold readData1/readData2; register writes still occur
regWrite  input  1  write enable
writeRegister  input  ADDR_W  write address
writeData  input  WIDTH  write data
readRegister1  input  ADDR_W  read address, port 1
readRegister2  input  ADDR_W  read address, port 2
immediate  input  1  1 = port 2 returns ltValue instead of a register
ltValue  input  WIDTH  immediate operand
readData1  output  WIDTH  registered read data, port 1
readData2  output  WIDTH  registered read data, port 2

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - all DEPTH registers = 0
  - readData1 = 0, readData2 = 0
  - reset asserted mid-operation aborts any write on that edge; state is 0 on the next cycle.
- Write: on a rising edge with regWrite=1, registers[writeRegister] <= writeData.
  - If ZERO_REG=1 and writeRegister=0, the write is discarded.
  - stall does not block writes.
- Read latency is 1 cycle. On a rising edge with stall=0:
  - readData1 <= value(readRegister1)
  - readData2 <= immediate ? ltValue : value(readRegister2)
- With stall=1, readData1 and readData2 hold their previous values.
- value(a): 0 if ZERO_REG=1 and a=0; otherwise the forwarding rule below applies, or else registers[a].
- Both ports may address the same register; each returns the identical value.
- ltValue is taken at full WIDTH with no extension. immediate has no effect on port 1.
- Addresses are always in range because DEPTH is a power of two. There is no wrap or out-of-range case.
- No X may propagate to the outputs after reset.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: if regWrite=1 and writeRegister equals a read address on the same edge, that port captures writeData (write-first).
  - This is subject to the ZERO_REG rule: register 0 still reads 0.
  - On port 2, forwarding does not apply when immediate=1.
- Undefined: the read captures the pre-write register contents (read-first). The new value is visible on a read issued the following cycle.

Test Plan:
1. Reset: assert reset with nonzero outputs -> readData1=readData2=0 immediately (asynchronously). After release, reading all 8 addresses returns 0.
2. Write then read: write 0xA5 to r3 in cycle 0, read r3 on both ports in cycle 1 -> readData1=readData2=0xA5 after that edge.
3. Immediate mode: r2=0x11, immediate=1, ltValue=0x7E, readRegister1=2 -> readData1=0x11, readData2=0x7E. Then immediate=0, readRegister2=2 -> readData2=0x11.
4. Read-during-write: r5=0x22, then the same edge has write r5<=0x99 and read r5 -> readData1=0x99 with REGFILE_BYPASS_EN, 0x22 without it. Next cycle, both builds read 0x99.
5. Stall: readData1=0x33, stall=1 for 3 cycles while writing r1<=0x44 and readRegister1 changes -> readData1 stays 0x33. Release stall with readRegister1=1 -> readData1=0x44.
6. ZERO_REG=1, WIDTH=16, DEPTH=16: write 0xBEEF to r0 and 0x1234 to r15 -> r0 reads 0x0000 (also under same-edge bypass), r15 reads 0x1234. Reset asserted mid-write -> r15 reads 0.

Source files
------------

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file, one write port, two registered read ports.
// Define REGFILE_BYPASS_EN for write-first forwarding; the default build is read-first.
module reg_file_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeRegister,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [ADDR_W-1:0] readRegister1,
    input  logic [ADDR_W-1:0] readRegister2,
    input  logic              immediate,
    input  logic [WIDTH-1:0]  ltValue,
    output logic [WIDTH-1:0]  readData1,
    output logic [WIDTH-1:0]  readData2
);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;

    // Register 0 reads as zero before any forwarding is considered.
    always_comb begin
        wr_en = regWrite && !(ZERO_REG && writeRegister == '0);
        val1  = (ZERO_REG && readRegister1 == '0) ? '0 :
                (BYPASS && regWrite && writeRegister == readRegister1) ? writeData :
                regs[readRegister1];
        val2  = immediate ? ltValue :
                (ZERO_REG && readRegister2 == '0) ? '0 :
                (BYPASS && regWrite && writeRegister == readRegister2) ? writeData :
                regs[readRegister2];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[writeRegister] <= writeData;
        end
    end

    // Stall freezes only the read outputs; writes above proceed regardless.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readData1 <= '0;
            readData2 <= '0;
        end else if (!stall) begin
            readData1 <= val1;
            readData2 <= val2;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed bench for reg_file_param (default 8x8 and 16x16 with zero register),
// checked every cycle against a rule-level model plus hand-computed literals.
module tb_reg_file_param;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       a_stall = 0, a_we = 0, a_imm = 0;
    logic [2:0] a_wa = 0, a_r1 = 0, a_r2 = 0;
    logic [7:0] a_wd = 0, a_lt = 0, a_rd1, a_rd2;

    logic        b_stall = 0, b_we = 0, b_imm = 0;
    logic [3:0]  b_wa = 0, b_r1 = 0, b_r2 = 0;
    logic [15:0] b_wd = 0, b_lt = 0, b_rd1, b_rd2;

    reg_file_param u0 (
        .clock(clock), .reset(reset), .stall(a_stall), .regWrite(a_we),
        .writeRegister(a_wa), .writeData(a_wd), .readRegister1(a_r1),
        .readRegister2(a_r2), .immediate(a_imm), .ltValue(a_lt),
        .readData1(a_rd1), .readData2(a_rd2)
    );

    reg_file_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) u1 (
        .clock(clock), .reset(reset), .stall(b_stall), .regWrite(b_we),
        .writeRegister(b_wa), .writeData(b_wd), .readRegister1(b_r1),
        .readRegister2(b_r2), .immediate(b_imm), .ltValue(b_lt),
        .readData1(b_rd1), .readData2(b_rd2)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    logic [7:0]  m0 [8];
    logic [15:0] m1 [16];
    logic [7:0]  e0_1, e0_2;
    logic [15:0] e1_1, e1_2;

    // Model: what each read sees is the register before this edge's write,
    // unless forwarding applies; register 0 of the second instance is constant zero.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m0[i] <= 8'h0;
            for (int i = 0; i < 16; i++) m1[i] <= 16'h0;
            e0_1 <= 8'h0; e0_2 <= 8'h0; e1_1 <= 16'h0; e1_2 <= 16'h0;
        end else begin
            if (!a_stall) begin
                e0_1 <= (BYP && a_we && a_wa == a_r1) ? a_wd : m0[a_r1];
                e0_2 <= a_imm ? a_lt : (BYP && a_we && a_wa == a_r2) ? a_wd : m0[a_r2];
            end
            if (a_we) m0[a_wa] <= a_wd;
            if (!b_stall) begin
                e1_1 <= (b_r1 == 0) ? 16'h0 : (BYP && b_we && b_wa == b_r1) ? b_wd : m1[b_r1];
                e1_2 <= b_imm ? b_lt : (b_r2 == 0) ? 16'h0 :
                        (BYP && b_we && b_wa == b_r2) ? b_wd : m1[b_r2];
            end
            if (b_we && b_wa != 0) m1[b_wa] <= b_wd;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            checks += 4;
            if (a_rd1 !== e0_1) begin errors++; $display("FAIL model_a_rd1 t=%0t got=%h want=%h", $time, a_rd1, e0_1); end
            if (a_rd2 !== e0_2) begin errors++; $display("FAIL model_a_rd2 t=%0t got=%h want=%h", $time, a_rd2, e0_2); end
            if (b_rd1 !== e1_1) begin errors++; $display("FAIL model_b_rd1 t=%0t got=%h want=%h", $time, b_rd1, e1_1); end
            if (b_rd2 !== e1_2) begin errors++; $display("FAIL model_b_rd2 t=%0t got=%h want=%h", $time, b_rd2, e1_2); end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick(); tick();
        reset = 0;
        chk_en = 1;
        // all registers read zero after reset
        for (int i = 0; i < 8; i++) begin
            a_r1 = 3'(i); a_r2 = 3'(7 - i);
            tick();
            check("reset_read", {8'h0, a_rd1}, 16'h0000);
        end
        // write then read
        a_we = 1; a_wa = 3; a_wd = 8'hA5; tick();
        a_we = 0; a_r1 = 3; a_r2 = 3; tick();
        check("wr_rd_p1", {8'h0, a_rd1}, 16'h00A5);
        check("wr_rd_p2", {8'h0, a_rd2}, 16'h00A5);
        // immediate mode
        a_we = 1; a_wa = 2; a_wd = 8'h11; tick();
        a_we = 0; a_imm = 1; a_lt = 8'h7E; a_r1 = 2; a_r2 = 3; tick();
        check("imm_p1", {8'h0, a_rd1}, 16'h0011);
        check("imm_p2", {8'h0, a_rd2}, 16'h007E);
        a_imm = 0; a_r2 = 2; tick();
        check("imm_off_p2", {8'h0, a_rd2}, 16'h0011);
        // read during write
        a_we = 1; a_wa = 5; a_wd = 8'h22; tick();
        a_wd = 8'h99; a_r1 = 5; a_r2 = 5; tick();
        check("rdw_p1", {8'h0, a_rd1}, BYP ? 16'h0099 : 16'h0022);
        a_we = 0; tick();
        check("rdw_next", {8'h0, a_rd1}, 16'h0099);
        // forwarding never overrides the immediate on port 2
        a_we = 1; a_wa = 4; a_wd = 8'h5A; a_r2 = 4; a_imm = 1; a_lt = 8'h0F; tick();
        check("imm_over_fwd", {8'h0, a_rd2}, 16'h000F);
        a_we = 0; a_imm = 0; tick();
        check("fwd_wrote", {8'h0, a_rd2}, 16'h005A);
        // stall holds outputs while writes continue
        a_we = 1; a_wa = 1; a_wd = 8'h33; tick();
        a_we = 0; a_r1 = 1; tick();
        check("pre_stall", {8'h0, a_rd1}, 16'h0033);
        a_stall = 1; a_we = 1; a_wd = 8'h44;
        for (int i = 0; i < 3; i++) begin
            a_r1 = 3'(i + 3);
            tick();
            check("stall_hold", {8'h0, a_rd1}, 16'h0033);
        end
        a_stall = 0; a_we = 0; a_r1 = 1; tick();
        check("stall_release", {8'h0, a_rd1}, 16'h0044);
        // zero register and wide configuration
        b_we = 1; b_wa = 0; b_wd = 16'hBEEF; tick();
        b_wa = 15; b_wd = 16'h1234; tick();
        b_we = 0; b_r1 = 0; b_r2 = 15; tick();
        check("zr_r0", b_rd1, 16'h0000);
        check("zr_r15", b_rd2, 16'h1234);
        b_we = 1; b_wa = 0; b_wd = 16'hBEEF; b_r1 = 0; b_r2 = 0; tick();
        check("zr_fwd_p1", b_rd1, 16'h0000);
        check("zr_fwd_p2", b_rd2, 16'h0000);
        b_we = 0; b_r1 = 15; b_r2 = 0; b_imm = 1; b_lt = 16'hFFFF; tick();
        check("zr_imm", b_rd2, 16'hFFFF);
        b_imm = 0;
        // asynchronous reset in the middle of a write
        b_we = 1; b_wa = 15; b_wd = 16'h5555;
        a_we = 1; a_wa = 1; a_wd = 8'h77;
        @(negedge clock); #2;
        reset = 1; #1;
        check("async_a_rd1", {8'h0, a_rd1}, 16'h0000);
        check("async_b_rd1", b_rd1, 16'h0000);
        tick();
        reset = 0; b_we = 0; a_we = 0; a_r1 = 1; b_r1 = 15; tick();
        check("reset_abort_a", {8'h0, a_rd1}, 16'h0000);
        check("reset_abort_b", b_rd1, 16'h0000);
        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
